// File: rtl/regfile_wr_sched.sv
// Write-port scheduler for the accumulator register file: arbitrates LUT/ALU/set writes and runs
// a one-register-per-cycle clear sequence. Define REGFILE_SCHED_RR_EN for ALU/set round-robin.
module regfile_wr_sched #(
  parameter int unsigned PW = 4,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          lut_req,
  input  logic [DW-1:0] lut_data,
  output logic          lut_gnt,
  input  logic          alu_req,
  input  logic [DW-1:0] alu_data,
  output logic          alu_gnt,
  input  logic          set_req,
  input  logic [PW-1:0] set_addr,
  output logic          set_gnt,
  input  logic [DW-1:0] acc_data,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          rf_wr_en,
  output logic [PW-1:0] rf_wr_addr,
  output logic [DW-1:0] rf_wr_data
);

  typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

  state_e        state_q;
  logic [PW-1:0] cnt_q;
`ifdef REGFILE_SCHED_RR_EN
  logic          ptr_q;  // 0: ALU has the turn, 1: set has the turn
`endif

  logic lut_ok, alu_ok, set_ok, r0_pending;
  logic alu_win, set_win;

  // An r0 write still on the port has not reached the file, so acc_data is stale.
  assign r0_pending = rf_wr_en && (rf_wr_addr == '0);
  assign lut_ok     = lut_req && !lut_gnt;
  assign alu_ok     = alu_req && !alu_gnt;
  assign set_ok     = set_req && !set_gnt && !r0_pending;

  always_comb begin
    alu_win = 1'b0;
    set_win = 1'b0;
    if (!lut_ok) begin
`ifdef REGFILE_SCHED_RR_EN
      if (alu_ok && set_ok) begin
        alu_win = !ptr_q;
        set_win = ptr_q;
      end else begin
        alu_win = alu_ok;
        set_win = set_ok;
      end
`else
      alu_win = alu_ok;
      set_win = !alu_ok && set_ok;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      lut_gnt    <= 1'b0;
      alu_gnt    <= 1'b0;
      set_gnt    <= 1'b0;
      clr_busy   <= 1'b0;
      clr_done   <= 1'b0;
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
`ifdef REGFILE_SCHED_RR_EN
      ptr_q      <= 1'b0;
`endif
    end else begin
      lut_gnt    <= 1'b0;
      alu_gnt    <= 1'b0;
      set_gnt    <= 1'b0;
      clr_busy   <= 1'b0;
      clr_done   <= 1'b0;
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      unique case (state_q)
        StIdle: begin
          if (clr_req) begin
            // First clear write goes out immediately; cnt_q is always 0 here.
            state_q    <= StClear;
            clr_busy   <= 1'b1;
            rf_wr_en   <= 1'b1;
            rf_wr_addr <= cnt_q;
            cnt_q      <= cnt_q + 1'b1;
          end else if (lut_ok) begin
            lut_gnt    <= 1'b1;
            rf_wr_en   <= 1'b1;
            rf_wr_data <= lut_data;
          end else if (alu_win) begin
            alu_gnt    <= 1'b1;
            rf_wr_en   <= 1'b1;
            rf_wr_data <= alu_data;
`ifdef REGFILE_SCHED_RR_EN
            ptr_q      <= 1'b1;
`endif
          end else if (set_win) begin
            set_gnt    <= 1'b1;
            rf_wr_en   <= 1'b1;
            rf_wr_addr <= set_addr;
            rf_wr_data <= acc_data;
`ifdef REGFILE_SCHED_RR_EN
            ptr_q      <= 1'b0;
`endif
          end
        end
        StClear: begin
          clr_busy   <= 1'b1;
          rf_wr_en   <= 1'b1;
          rf_wr_addr <= cnt_q;
          cnt_q      <= cnt_q + 1'b1;
          if (cnt_q == '1) state_q <= StDone;
        end
        StDone: begin
          clr_done <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
